reg_timer_pwm: RTL and testbench

//  Timer/PWM peripheral that consumes the rw_regs configuration bus exported by the SPI/I2C

---
 rtl/reg_timer_pwm.sv | 175 +++++++++++++++++
 tb/tb_reg_timer_pwm.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/reg_timer_pwm.sv
// Timer/PWM peripheral driven by the register bank's rw_regs bus, reporting status on ro_regs.
// Optional wrap counter (ro_regs reg3) is built when TIMER_WRAPCNT_EN is defined.
module reg_timer_pwm #(
    parameter int unsigned NUM_CFG    = 8,
    parameter int unsigned NUM_STATUS = 8,
    parameter int unsigned REG_WIDTH  = 8,
    parameter logic [15:0] ID_VALUE   = 16'hCA10
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NUM_CFG*REG_WIDTH-1:0]    rw_regs,
    output logic [NUM_STATUS*REG_WIDTH-1:0] ro_regs,
    output logic                            pwm_o,
    output logic                            wrap_o
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } state_e;

    state_e state_q, state_d;

    logic [7:0]  ctrl;
    logic [7:0]  prescale;
    logic [15:0] period;
    logic [15:0] compare;
    logic        en, oneshot, clr, ack;

    logic        en_low_q, en_low_d;
    logic        ack_low_q, ack_low_d;
    logic        en_rise, ack_rise;

    logic [7:0]  presc_q, presc_d;
    logic [15:0] cnt_q, cnt_d;
    logic        wrap_flag_q, wrap_flag_d;
    logic        done_flag_q, done_flag_d;
    logic        pwm_q, pwm_d;
    logic        wrap_q, wrap_d;
    logic [7:0]  wrapcnt;

    logic        tick;
    logic        at_end;
    logic        wrap_evt;
    logic [7:0]  status;

    assign ctrl     = rw_regs[7:0];
    assign prescale = rw_regs[15:8];
    assign period   = rw_regs[31:16];
    assign compare  = rw_regs[47:32];
    assign en       = ctrl[0];
    assign oneshot  = ctrl[1];
    assign clr      = ctrl[2];
    assign ack      = ctrl[3];

    logic ctrl_unused;
    assign ctrl_unused = ^ctrl[7:4];

    if (NUM_CFG > 8) begin : g_extra_cfg
        logic extra_cfg_unused;
        assign extra_cfg_unused = ^rw_regs[NUM_CFG*REG_WIDTH-1:8*REG_WIDTH];
    end

    // Edge detectors remember "input was low last cycle"; resetting them to 0
    // means a level already high at reset exit is not seen as a rising edge.
    assign en_low_d  = ~en;
    assign ack_low_d = ~ack;
    assign en_rise   = en & en_low_q;
    assign ack_rise  = ack & ack_low_q;

    always_comb begin
        tick     = (state_q == ST_RUN) && (presc_q >= prescale);
        at_end   = (cnt_q >= period);
        wrap_evt = tick && at_end && !clr;

        presc_d = presc_q;
        if (clr || (state_q != ST_RUN) || tick) begin
            presc_d = '0;
        end else begin
            presc_d = presc_q + 8'd1;
        end

        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (tick) begin
            cnt_d = at_end ? 16'd0 : cnt_q + 16'd1;
        end

        state_d = state_q;
        case (state_q)
            ST_IDLE: if (en_rise) state_d = ST_RUN;
            ST_RUN: begin
                if (!en) begin
                    state_d = ST_IDLE;
                end else if (wrap_evt && oneshot) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: if (!en) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        // A wrap in the same cycle as an ACK edge wins, so no event is lost.
        wrap_flag_d = wrap_evt | (wrap_flag_q & ~ack_rise);
        done_flag_d = (wrap_evt & oneshot) | (done_flag_q & ~ack_rise);

        pwm_d  = (state_q == ST_RUN) && (cnt_q < compare);
        wrap_d = wrap_evt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            en_low_q    <= 1'b0;
            ack_low_q   <= 1'b0;
            presc_q     <= '0;
            cnt_q       <= '0;
            wrap_flag_q <= 1'b0;
            done_flag_q <= 1'b0;
            pwm_q       <= 1'b0;
            wrap_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            en_low_q    <= en_low_d;
            ack_low_q   <= ack_low_d;
            presc_q     <= presc_d;
            cnt_q       <= cnt_d;
            wrap_flag_q <= wrap_flag_d;
            done_flag_q <= done_flag_d;
            pwm_q       <= pwm_d;
            wrap_q      <= wrap_d;
        end
    end

`ifdef TIMER_WRAPCNT_EN
    logic [7:0] wrapcnt_q, wrapcnt_d;

    always_comb begin
        wrapcnt_d = wrapcnt_q;
        if (clr) begin
            wrapcnt_d = '0;
        end else if (wrap_evt) begin
            wrapcnt_d = wrapcnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wrapcnt_q <= '0;
        end else begin
            wrapcnt_q <= wrapcnt_d;
        end
    end

    assign wrapcnt = wrapcnt_q;
`else
    assign wrapcnt = '0;
`endif

    assign status = {5'b0, done_flag_q, wrap_flag_q, (state_q == ST_RUN)};
    assign pwm_o  = pwm_q;
    assign wrap_o = wrap_q;

    always_comb begin
        ro_regs        = '0;
        ro_regs[15:0]  = cnt_q;
        ro_regs[23:16] = status;
        ro_regs[31:24] = wrapcnt;
        ro_regs[55:48] = ID_VALUE[7:0];
        ro_regs[63:56] = ID_VALUE[15:8];
    end

endmodule

// File: tb/tb_reg_timer_pwm.sv
// Directed self-checking bench for reg_timer_pwm; inputs change and outputs are sampled on negedge.
module tb_reg_timer_pwm;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [63:0] rw_regs = '0;
    logic [63:0] ro_regs;
    logic        pwm_o;
    logic        wrap_o;

    int checks   = 0;
    int failures = 0;

    logic [15:0] cnt_v;
    logic [7:0]  status_v;
    logic [7:0]  wrapcnt_v;
    assign cnt_v     = ro_regs[15:0];
    assign status_v  = ro_regs[23:16];
    assign wrapcnt_v = ro_regs[31:24];

    localparam logic [63:0] RESET_RO = 64'hCA10_0000_0000_0000;

    reg_timer_pwm #(
        .NUM_CFG   (8),
        .NUM_STATUS(8),
        .REG_WIDTH (8),
        .ID_VALUE  (16'hCA10)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .rw_regs(rw_regs),
        .ro_regs(ro_regs),
        .pwm_o  (pwm_o),
        .wrap_o (wrap_o)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] exp_wc(input int n);
`ifdef TIMER_WRAPCNT_EN
        return 8'(n);
`else
        return 8'h00;
`endif
    endfunction

    task automatic step();
        @(negedge clk);
    endtask

    task automatic set_ctrl(input logic [7:0] c);
        rw_regs[7:0] = c;
    endtask

    task automatic set_cfg(input logic [7:0] p, input logic [15:0] per, input logic [15:0] cmp);
        rw_regs[15:8]  = p;
        rw_regs[31:16] = per;
        rw_regs[47:32] = cmp;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Reset, configure, hold EN low one cycle, then apply ctrl; next posedge is cycle 1.
    task automatic start_fresh(input logic [7:0] p, input logic [15:0] per,
                               input logic [15:0] cmp, input logic [7:0] c);
        set_ctrl(8'h00);
        do_reset();
        set_cfg(p, per, cmp);
        step();
        set_ctrl(c);
    endtask

    task automatic test_reset();
        set_ctrl(8'h00);
        set_cfg(8'h00, 16'h0000, 16'h0000);
        do_reset();
        checks++; if (ro_regs !== RESET_RO) begin failures++; $display("FAIL reset_ro got=%h exp=%h", ro_regs, RESET_RO); end
        checks++; if (pwm_o !== 1'b0) begin failures++; $display("FAIL reset_pwm got=%b exp=0", pwm_o); end
        checks++; if (wrap_o !== 1'b0) begin failures++; $display("FAIL reset_wrap got=%b exp=0", wrap_o); end
        step(); step();
        checks++; if (ro_regs !== RESET_RO) begin failures++; $display("FAIL reset_idle_ro got=%h exp=%h", ro_regs, RESET_RO); end
        set_ctrl(8'h01);
        do_reset();
        step(); step(); step();
        checks++; if (status_v !== 8'h00) begin failures++; $display("FAIL en_held_status got=%h exp=00", status_v); end
        checks++; if (cnt_v !== 16'd0) begin failures++; $display("FAIL en_held_cnt got=%h exp=0", cnt_v); end
        set_ctrl(8'h00);
        step();
        set_ctrl(8'h01);
        step();
        checks++; if (status_v !== 8'h01) begin failures++; $display("FAIL en_edge_start got=%h exp=01", status_v); end
    endtask

    task automatic test_continuous();
        logic [15:0] e;
        start_fresh(8'd0, 16'd4, 16'd2, 8'h01);
        step();
        checks++; if (cnt_v !== 16'd0) begin failures++; $display("FAIL cont_start_cnt got=%h exp=0", cnt_v); end
        checks++; if (status_v !== 8'h01) begin failures++; $display("FAIL cont_running got=%h exp=01", status_v); end
        checks++; if (pwm_o !== 1'b0) begin failures++; $display("FAIL cont_start_pwm got=%b exp=0", pwm_o); end
        for (int k = 0; k < 10; k++) begin
            step();
            e = 16'((k + 1) % 5);
            checks++; if (cnt_v !== e) begin failures++; $display("FAIL cont_cnt k=%0d got=%0d exp=%0d", k, cnt_v, e); end
            checks++; if (pwm_o !== (e == 16'd1 || e == 16'd2)) begin failures++; $display("FAIL cont_pwm k=%0d got=%b exp=%b", k, pwm_o, (e == 16'd1 || e == 16'd2)); end
            checks++; if (wrap_o !== (e == 16'd0)) begin failures++; $display("FAIL cont_wrap k=%0d got=%b exp=%b", k, wrap_o, (e == 16'd0)); end
        end
        checks++; if (wrapcnt_v !== exp_wc(2)) begin failures++; $display("FAIL cont_wrapcnt got=%0d exp=%0d", wrapcnt_v, exp_wc(2)); end
        checks++; if (status_v !== 8'h03) begin failures++; $display("FAIL cont_status got=%h exp=03", status_v); end
    endtask

    task automatic test_prescale();
        logic [15:0] ecnt;
        logic        ewrap;
        start_fresh(8'd3, 16'd1, 16'd0, 8'h01);
        for (int k = 1; k <= 24; k++) begin
            step();
            ecnt  = (k < 5) ? 16'd0 : ((((k - 5) / 4) % 2 == 0) ? 16'd1 : 16'd0);
            ewrap = (k == 9) || (k == 17);
            checks++; if (cnt_v !== ecnt) begin failures++; $display("FAIL presc_cnt k=%0d got=%0d exp=%0d", k, cnt_v, ecnt); end
            checks++; if (wrap_o !== ewrap) begin failures++; $display("FAIL presc_wrap k=%0d got=%b exp=%b", k, wrap_o, ewrap); end
            checks++; if (pwm_o !== 1'b0) begin failures++; $display("FAIL presc_pwm_cmp0 k=%0d got=%b exp=0", k, pwm_o); end
        end
        checks++; if (wrapcnt_v !== exp_wc(2)) begin failures++; $display("FAIL presc_wrapcnt got=%0d exp=%0d", wrapcnt_v, exp_wc(2)); end
    endtask

    task automatic test_oneshot();
        start_fresh(8'd0, 16'd9, 16'd5, 8'h03);
        for (int k = 1; k <= 20; k++) begin
            step();
            checks++; if (wrap_o !== (k == 11)) begin failures++; $display("FAIL os_wrap k=%0d got=%b exp=%b", k, wrap_o, (k == 11)); end
            if (k == 10) begin
                checks++; if (cnt_v !== 16'd9) begin failures++; $display("FAIL os_cnt_pre got=%0d exp=9", cnt_v); end
                checks++; if (status_v !== 8'h01) begin failures++; $display("FAIL os_status_pre got=%h exp=01", status_v); end
            end
            if (k >= 11) begin
                checks++; if (cnt_v !== 16'd0) begin failures++; $display("FAIL os_cnt_done k=%0d got=%0d exp=0", k, cnt_v); end
                checks++; if (pwm_o !== 1'b0) begin failures++; $display("FAIL os_pwm_done k=%0d got=%b exp=0", k, pwm_o); end
                checks++; if (status_v !== 8'h06) begin failures++; $display("FAIL os_status_done k=%0d got=%h exp=06", k, status_v); end
            end
        end
        set_ctrl(8'h02);
        step();
        checks++; if (status_v !== 8'h06) begin failures++; $display("FAIL os_idle_status got=%h exp=06", status_v); end
        set_ctrl(8'h03);
        step();
        checks++; if (status_v !== 8'h07) begin failures++; $display("FAIL os_restart_status got=%h exp=07", status_v); end
        step();
        checks++; if (cnt_v !== 16'd1) begin failures++; $display("FAIL os_restart_cnt got=%0d exp=1", cnt_v); end
    endtask

    task automatic test_ack_same_cycle();
        start_fresh(8'd0, 16'd4, 16'd0, 8'h01);
        repeat (10) step();
        checks++; if (status_v[1] !== 1'b1) begin failures++; $display("FAIL ack_pre_flag got=%b exp=1", status_v[1]); end
        set_ctrl(8'h09);
        step();
        checks++; if (wrap_o !== 1'b1) begin failures++; $display("FAIL ack_coincide_wrap got=%b exp=1", wrap_o); end
        checks++; if (status_v[1] !== 1'b1) begin failures++; $display("FAIL ack_coincide_flag got=%b exp=1", status_v[1]); end
        set_ctrl(8'h01);
        step();
        checks++; if (status_v[1] !== 1'b1) begin failures++; $display("FAIL ack_low_flag got=%b exp=1", status_v[1]); end
        set_ctrl(8'h09);
        step();
        checks++; if (status_v[1] !== 1'b0) begin failures++; $display("FAIL ack_clear_flag got=%b exp=0", status_v[1]); end
        checks++; if (wrap_o !== 1'b0) begin failures++; $display("FAIL ack_clear_wrap got=%b exp=0", wrap_o); end
    endtask

    task automatic test_clear_and_reset();
        start_fresh(8'd0, 16'd1, 16'd30, 8'h01);
        repeat (5) step();
        checks++; if (wrapcnt_v !== exp_wc(2)) begin failures++; $display("FAIL clr_pre_wrapcnt got=%0d exp=%0d", wrapcnt_v, exp_wc(2)); end
        set_cfg(8'd0, 16'd20, 16'd30);
        repeat (7) step();
        checks++; if (cnt_v !== 16'd7) begin failures++; $display("FAIL clr_pre_cnt got=%0d exp=7", cnt_v); end
        checks++; if (pwm_o !== 1'b1) begin failures++; $display("FAIL clr_pwm_cmp_gt_per got=%b exp=1", pwm_o); end
        set_ctrl(8'h05);
        step();
        checks++; if (cnt_v !== 16'd0) begin failures++; $display("FAIL clr_cnt got=%0d exp=0", cnt_v); end
        checks++; if (wrapcnt_v !== 8'd0) begin failures++; $display("FAIL clr_wrapcnt got=%0d exp=0", wrapcnt_v); end
        checks++; if (wrap_o !== 1'b0) begin failures++; $display("FAIL clr_no_wrap got=%b exp=0", wrap_o); end
        checks++; if (status_v[0] !== 1'b1) begin failures++; $display("FAIL clr_fsm_kept got=%b exp=1", status_v[0]); end
        step();
        checks++; if (cnt_v !== 16'd0) begin failures++; $display("FAIL clr_hold_cnt got=%0d exp=0", cnt_v); end
        set_ctrl(8'h01);
        step();
        checks++; if (cnt_v !== 16'd1) begin failures++; $display("FAIL clr_release_cnt got=%0d exp=1", cnt_v); end
        rst = 1'b1;
        step();
        checks++; if (ro_regs !== RESET_RO) begin failures++; $display("FAIL midrun_reset_ro got=%h exp=%h", ro_regs, RESET_RO); end
        checks++; if (pwm_o !== 1'b0) begin failures++; $display("FAIL midrun_reset_pwm got=%b exp=0", pwm_o); end
        rst = 1'b0;
    endtask

    task automatic test_period_boundaries();
        start_fresh(8'd0, 16'd20, 16'd0, 8'h01);
        repeat (11) step();
        checks++; if (cnt_v !== 16'd10) begin failures++; $display("FAIL per_pre_cnt got=%0d exp=10", cnt_v); end
        set_cfg(8'd0, 16'd3, 16'd0);
        step();
        checks++; if (cnt_v !== 16'd0) begin failures++; $display("FAIL per_lower_cnt got=%0d exp=0", cnt_v); end
        checks++; if (wrap_o !== 1'b1) begin failures++; $display("FAIL per_lower_wrap got=%b exp=1", wrap_o); end
        set_cfg(8'd0, 16'd0, 16'd0);
        for (int k = 0; k < 2; k++) begin
            step();
            checks++; if (wrap_o !== 1'b1) begin failures++; $display("FAIL per0_wrap k=%0d got=%b exp=1", k, wrap_o); end
            checks++; if (cnt_v !== 16'd0) begin failures++; $display("FAIL per0_cnt k=%0d got=%0d exp=0", k, cnt_v); end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        @(negedge clk);
        test_reset();
        test_continuous();
        test_prescale();
        test_oneshot();
        test_ack_same_cycle();
        test_clear_and_reset();
        test_period_boundaries();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
